// File: rtl/can_rx_edge_filter.sv
// Multi-channel CAN RX conditioning: synchronizer, programmable glitch filter,
// mode-selectable edge detector and bus-idle tracker; config shared, state per channel.
module can_rx_edge_filter #(
    parameter int unsigned NCH         = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4,
    parameter int unsigned IDLE_W      = 8
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [NCH-1:0]    rx_in,
    input  logic [1:0]        edge_mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [IDLE_W-1:0] idle_len,
    output logic [NCH-1:0]    rx_filt,
    output logic [NCH-1:0]    edge_pulse,
    output logic [NCH-1:0]    edge_rise,
    output logic [NCH-1:0]    bus_idle
);

    // One extra bit so cnt+1 never wraps when compared with the limit
    localparam int unsigned CNT_W = FILT_W + 1;

    localparam logic [1:0] MODE_FALL = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [CNT_W-1:0] w_filt_lim;
    logic             w_allow_fall;
    logic             w_allow_rise;
    logic             w_idle_en;

    // Shared configuration decode; a zero filter length behaves as one
    always_comb begin
        w_filt_lim   = (filt_len == '0) ? CNT_W'(1) : CNT_W'(filt_len);
        w_allow_fall = (edge_mode == MODE_FALL) || (edge_mode == MODE_BOTH);
        w_allow_rise = (edge_mode == MODE_RISE) || (edge_mode == MODE_BOTH);
        w_idle_en    = (idle_len != '0);
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_filt;
        logic                   r_prev;
        logic [FILT_W-1:0]      r_cnt;
        logic [IDLE_W-1:0]      r_idle_cnt;

        logic                   w_sync;
        logic                   w_cnt_done;
        logic                   w_filt_nxt;
        logic [FILT_W-1:0]      w_cnt_nxt;
        logic [IDLE_W-1:0]      w_idle_nxt;
        logic                   w_raw_edge;
        logic                   w_pulse;

        assign w_sync     = r_sync[SYNC_STAGES-1];
        assign w_cnt_done = (CNT_W'(r_cnt) + CNT_W'(1)) >= w_filt_lim;

        // Filter: accept a new level only after L consecutive mismatching cycles
        always_comb begin
            w_cnt_nxt  = r_cnt;
            w_filt_nxt = r_filt;
            if (w_sync == r_filt) begin
                w_cnt_nxt = '0;
            end else if (w_cnt_done) begin
                w_filt_nxt = w_sync;
                w_cnt_nxt  = '0;
            end else begin
                w_cnt_nxt = r_cnt + FILT_W'(1);
            end
        end

        // Idle counter saturates at idle_len; a count left above a lowered
        // limit just holds, keeping bus_idle low until the next dominant bit
        always_comb begin
            w_idle_nxt = r_idle_cnt;
            if (!r_filt) begin
                w_idle_nxt = '0;
            end else if (r_idle_cnt < idle_len) begin
                w_idle_nxt = r_idle_cnt + IDLE_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (RST) begin
                r_sync     <= '1;
                r_filt     <= 1'b1;
                r_prev     <= 1'b1;
                r_cnt      <= '0;
                r_idle_cnt <= '0;
            end else begin
                r_sync     <= {r_sync[SYNC_STAGES-2:0], rx_in[ch]};
                r_filt     <= w_filt_nxt;
                r_prev     <= r_filt;
                r_cnt      <= w_cnt_nxt;
                r_idle_cnt <= w_idle_nxt;
            end
        end

        // Outputs decode registered state only; no path from rx_in
        assign w_raw_edge = r_filt ^ r_prev;
        assign w_pulse    = w_raw_edge & (r_filt ? w_allow_rise : w_allow_fall);

        assign rx_filt[ch]    = r_filt;
        assign edge_pulse[ch] = w_pulse;
        assign edge_rise[ch]  = w_pulse & r_filt;
        assign bus_idle[ch]   = w_idle_en && (r_idle_cnt == idle_len) && r_filt;
    end

endmodule

// File: tb/tb_can_rx_edge_filter.sv
// Directed bench for can_rx_edge_filter: a 4-channel instance plus a default
// single-channel instance sharing channel 0's input and all configuration.
module tb_can_rx_edge_filter;

    logic       clk;
    logic       RST;
    logic [3:0] rx;
    logic [1:0] edge_mode;
    logic [3:0] filt_len;
    logic [7:0] idle_len;

    logic [3:0] rx_filt4, pulse4, rise4, idle4;
    logic [0:0] rx_filt1, pulse1, rise1, idle1;

    int n_tests = 0;
    int n_fail  = 0;

    can_rx_edge_filter #(.NCH(4), .SYNC_STAGES(2), .FILT_W(4), .IDLE_W(8)) u_dut4 (
        .clk        (clk),
        .RST        (RST),
        .rx_in      (rx),
        .edge_mode  (edge_mode),
        .filt_len   (filt_len),
        .idle_len   (idle_len),
        .rx_filt    (rx_filt4),
        .edge_pulse (pulse4),
        .edge_rise  (rise4),
        .bus_idle   (idle4)
    );

    can_rx_edge_filter u_dut1 (
        .clk        (clk),
        .RST        (RST),
        .rx_in      (rx[0:0]),
        .edge_mode  (edge_mode),
        .filt_len   (filt_len),
        .idle_len   (idle_len),
        .rx_filt    (rx_filt1),
        .edge_pulse (pulse1),
        .edge_rise  (rise1),
        .bus_idle   (idle1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rx0;
        logic [1:0] mode;
        logic [3:0] filt;
        logic [7:0] idle;
        logic       f;
        logic       p;
        logic       r;
        logic       b;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [19:0] act();
        return {rx_filt4, pulse4, rise4, idle4, rx_filt1, pulse1, rise1, idle1};
    endfunction

    // Expected outputs when only channel 0 moves; b_oth is bus_idle of idle channels
    function automatic logic [19:0] mk(input logic f, input logic p, input logic r,
                                       input logic b0, input logic b_oth);
        return {3'b111, f, 3'b000, p, 3'b000, r, {3{b_oth}}, b0, f, p, r, b0};
    endfunction

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        rx  = 4'hF;
        repeat (n) step();
        RST = 1'b0;
    endtask

    initial begin
        int fall4, rse4, fall1, rse1, bad, cnt_idle;
        logic [3:0] ef, ep;

        // falling-only at defaults: rising transition yields no pulse
        tbl[0] = '{1'b1, 2'b00, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 2'b00, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 2'b00, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 2'b00, 4'd1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 2'b00, 4'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'b00, 4'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 2'b00, 4'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 2'b00, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 2'b00, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        RST       = 1'b1;
        rx        = 4'hF;
        edge_mode = 2'b00;
        filt_len  = 4'd1;
        idle_len  = 8'd0;
        do_reset(3);
        chk("reset_state", act(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < 9; i++) begin
            rx        = {3'b111, tbl[i].rx0};
            edge_mode = tbl[i].mode;
            filt_len  = tbl[i].filt;
            idle_len  = tbl[i].idle;
            step();
            chk($sformatf("vec%0d", i), act(), mk(tbl[i].f, tbl[i].p, tbl[i].r, tbl[i].b, 1'b0));
        end

        // Mode sweep: one falling then one rising transition per mode
        for (int m = 0; m < 4; m++) begin
            edge_mode = 2'(m);
            fall4 = 0; rse4 = 0; fall1 = 0; rse1 = 0; bad = 0;
            for (int i = 0; i < 12; i++) begin
                rx = (i < 6) ? 4'hE : 4'hF;
                step();
                if (pulse4[0] && !rise4[0]) fall4++;
                if (pulse4[0] &&  rise4[0]) rse4++;
                if (pulse1[0] && !rise1[0]) fall1++;
                if (pulse1[0] &&  rise1[0]) rse1++;
                if ((rise4 & ~pulse4) != 4'b0 || (rise1 & ~pulse1) != 1'b0) bad++;
                if (pulse4[3:1] != 3'b000) bad++;
            end
            chk($sformatf("mode%0d_counts", m),
                20'({4'(fall4), 4'(rse4), 4'(fall1), 4'(rse1), 4'(bad)}),
                20'({4'((m == 0 || m == 2) ? 1 : 0), 4'((m == 1 || m == 2) ? 1 : 0),
                     4'((m == 0 || m == 2) ? 1 : 0), 4'((m == 1 || m == 2) ? 1 : 0), 4'd0}));
        end

        // filt_len=4: a 3-cycle dominant glitch is discarded
        edge_mode = 2'b00;
        filt_len  = 4'd4;
        for (int i = 0; i < 10; i++) begin
            rx = (i < 3) ? 4'hE : 4'hF;
            step();
            chk($sformatf("glitch3_%0d", i), act(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        // filt_len=4: 4 dominant cycles accepted after edge k+5, rising back after k+9
        for (int i = 0; i < 12; i++) begin
            rx = (i < 4) ? 4'hE : 4'hF;
            step();
            chk($sformatf("low4_%0d", i), act(),
                mk((i >= 5 && i <= 8) ? 1'b0 : 1'b1, (i == 5), 1'b0, 1'b0, 1'b0));
        end

        // Idle: bus_idle after 11 recessive edges following reset
        filt_len = 4'd1;
        idle_len = 8'd11;
        do_reset(2);
        chk("idle_after_reset", act(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int j = 1; j <= 12; j++) begin
            step();
            chk($sformatf("idle_rise_%0d", j), act(),
                mk(1'b1, 1'b0, 1'b0, (j >= 11), (j >= 11)));
        end

        // Single dominant bit: bus_idle drops with rx_filt, returns 11 cycles later
        for (int i = 0; i < 16; i++) begin
            rx = (i == 0) ? 4'hE : 4'hF;
            step();
            chk($sformatf("idle_dom_%0d", i), act(),
                mk((i != 2), (i == 2), 1'b0, (i <= 1 || i >= 14), 1'b1));
        end

        // idle_len=0 disables bus_idle immediately and after reset
        idle_len = 8'd0;
        #1;
        chk("idle_disable_now", act(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        do_reset(1);
        cnt_idle = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (idle4 != 4'b0 || idle1 != 1'b0) cnt_idle++;
        end
        chk("idle_len0_never", 20'(cnt_idle), 20'd0);

        // Four channels: ch0/ch3 fall together, ch1 glitch rejected at filt_len=2
        filt_len = 4'd2;
        do_reset(1);
        for (int i = 0; i < 7; i++) begin
            rx = (i == 0) ? 4'b0100 : 4'b0110;
            step();
            ef = (i >= 3) ? 4'b0110 : 4'b1111;
            ep = (i == 3) ? 4'b1001 : 4'b0000;
            chk($sformatf("multi_%0d", i), act(),
                {ef, ep, 4'b0000, 4'b0000, ef[0], ep[0], 1'b0, 1'b0});
        end

        // Reset while channel 0 filter count sits at 3 of 4 with rx dominant
        filt_len = 4'd4;
        idle_len = 8'd3;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            rx = 4'hE;
            step();
        end
        chk("pre_reset_pending", act(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        RST = 1'b1;
        step();
        chk("mid_reset", act(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        RST = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step();
            chk($sformatf("post_reset_%0d", j), act(),
                mk((j < 6), (j == 6), 1'b0, (j >= 3 && j < 6), (j >= 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
